// File: rtl/an_encoder_n37_4x4_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | an_encoder_n37_4x4_if : message-in / codeword-block-out handshake bus  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface an_encoder_n37_4x4_if;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [12:0]  in_msg;
  logic         out_valid;
  logic         out_ready;
  logic [287:0] out_block;
  logic         blk_err;

  modport master (
    output clear, in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_block, blk_err
  );

  modport slave (
    input  clear, in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_block, blk_err
  );
endinterface
`default_nettype wire

// File: rtl/an_encoder_n37_4x4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | an_encoder_n37_4x4 : AN (A=37) encoder packing 16 codewords into a    |
// | 4x4 row-major block. Optional macro: AN_RANGE_CHECK_EN (m <= 7084).   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module an_encoder_n37_4x4 (
  input  logic                 clk,
  input  logic                 rst_n,
  an_encoder_n37_4x4_if.slave  bus
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [12:0] c_max_msg = 13'd7084;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [17:0] r_slot [16];
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic [17:0] w_m_ext;
  logic [17:0] w_enc;
  logic [17:0] w_codeword;
  logic        w_oor;

  // 37*m as shift-add; arithmetic modulo 2^18 equals the truncated 19-bit sum
  assign w_m_ext = {5'd0, bus.in_msg};
  assign w_enc   = (w_m_ext << 5) + (w_m_ext << 2) + w_m_ext;
  assign w_oor   = (bus.in_msg > c_max_msg);

`ifdef AN_RANGE_CHECK_EN
  assign w_codeword = w_oor ? 18'd0 : w_enc;
`else
  assign w_codeword = w_enc;
`endif

  // clear beats a simultaneous handshake
  assign w_accept = bus.in_valid & w_in_ready & ~bus.clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      FILL: begin
        w_in_ready = 1'b1;
        if (w_accept && (r_cnt == 4'd15)) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = FILL;
        end
      end
      default: begin
        w_state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      for (int i = 0; i < 16; i++) begin
        r_slot[i] <= 18'd0;
      end
    end else if (r_state == FILL) begin
      if (bus.clear) begin
        r_cnt <= 4'd0;
      end else if (w_accept) begin
        r_slot[r_cnt] <= w_codeword;
        r_cnt         <= r_cnt + 4'd1;
      end
    end
  end

`ifdef AN_RANGE_CHECK_EN
  logic r_blk_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_err <= 1'b0;
    end else if (r_state == FILL) begin
      if (bus.clear) begin
        r_blk_err <= 1'b0;
      end else if (w_accept && w_oor) begin
        r_blk_err <= 1'b1;
      end
    end else if (bus.out_ready) begin
      r_blk_err <= 1'b0;
    end
  end

  assign bus.blk_err = r_blk_err;
`else
  assign bus.blk_err = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_slot
      assign bus.out_block[18*gi +: 18] = r_slot[gi];
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_an_encoder_n37_4x4.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_an_encoder_n37_4x4 : directed-vector bench for an_encoder_n37_4x4  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_an_encoder_n37_4x4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [12:0]  msgs [16];
  logic [287:0] exp_blk;
  logic [287:0] held;

  an_encoder_n37_4x4_if bus ();

  an_encoder_n37_4x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] enc(input logic [12:0] m);
    logic [31:0] p;
    p = 32'(m) * 32'd37;
`ifdef AN_RANGE_CHECK_EN
    if (m > 13'd7084) p = 32'd0;
`endif
    return p[17:0];
  endfunction

  task automatic push(input logic [12:0] m);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_msg   = m;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // pushes msgs[0..15], checks out_valid only after the 16th accept
  task automatic fill_block(input string tag);
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      exp_blk[18*i +: 18] = enc(msgs[i]);
      if (i == 15) chk({tag, "_ov_pre"}, 288'(bus.out_valid), 288'(0));
      push(msgs[i]);
    end
    chk({tag, "_ov"}, 288'(bus.out_valid), 288'(1));
    chk({tag, "_ir"}, 288'(bus.in_ready), 288'(0));
    chk({tag, "_blk"}, bus.out_block, exp_blk);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_drain_ov"}, 288'(bus.out_valid), 288'(0));
    chk({tag, "_drain_ir"}, 288'(bus.in_ready), 288'(1));
    chk({tag, "_drain_err"}, 288'(bus.blk_err), 288'(0));
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_ov",  288'(bus.out_valid), 288'(0));
    chk("rst_blk", bus.out_block, 288'(0));
    chk("rst_err", 288'(bus.blk_err), 288'(0));
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ir", 288'(bus.in_ready), 288'(1));

    // slot index messages: slot i = 37*i
    for (int i = 0; i < 16; i++) msgs[i] = 13'(i);
    fill_block("seq");
    chk("seq_s15", 288'(bus.out_block[18*15 +: 18]), 288'(555));
    chk("seq_s1",  288'(bus.out_block[18*1 +: 18]), 288'(37));
    chk("seq_err", 288'(bus.blk_err), 288'(0));
    drain("seq");

    // range boundary
    for (int i = 0; i < 16; i++) msgs[i] = 13'(100 + i);
    msgs[0]  = 13'd7084;
    msgs[15] = 13'd1;
    fill_block("bnd");
    chk("bnd_s0",  288'(bus.out_block[17:0]), 288'(262108));
    chk("bnd_s15", 288'(bus.out_block[18*15 +: 18]), 288'(37));
    chk("bnd_err", 288'(bus.blk_err), 288'(0));
    drain("bnd");

    // just out of range in slot 3
    for (int i = 0; i < 16; i++) msgs[i] = 13'(i);
    msgs[3] = 13'd7085;
    fill_block("oor");
`ifdef AN_RANGE_CHECK_EN
    chk("oor_s3",  288'(bus.out_block[18*3 +: 18]), 288'(0));
    chk("oor_err", 288'(bus.blk_err), 288'(1));
`else
    chk("oor_s3",  288'(bus.out_block[18*3 +: 18]), 288'(1));
    chk("oor_err", 288'(bus.blk_err), 288'(0));
`endif
    drain("oor");

    // backpressure: hold stable, inputs and clear ignored
    for (int i = 0; i < 16; i++) msgs[i] = 13'(200 + i);
    fill_block("bp");
    held = bus.out_block;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_msg   = 13'(8191 - k);
      bus.clear    = (k == 2);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.clear    = 1'b0;
      chk("bp_stable", bus.out_block, held);
      chk("bp_ov", 288'(bus.out_valid), 288'(1));
      chk("bp_ir", 288'(bus.in_ready), 288'(0));
    end
    drain("bp");
    for (int i = 0; i < 16; i++) msgs[i] = 13'(300 + i);
    fill_block("bp2");
    drain("bp2");

    // clear after 7 accepts, together with in_valid
    push(13'd7085);
    for (int i = 1; i < 7; i++) push(13'(500 + i));
    @(negedge clk);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_msg   = 13'd1234;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_ir", 288'(bus.in_ready), 288'(1));
    for (int i = 0; i < 16; i++) msgs[i] = 13'(600 + i);
    fill_block("clr");
    chk("clr_err", 288'(bus.blk_err), 288'(0));
    drain("clr");

    // reset mid-fill
    for (int i = 0; i < 9; i++) push(13'(700 + i));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_ov",  288'(bus.out_valid), 288'(0));
    chk("mrst_blk", bus.out_block, 288'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_ir", 288'(bus.in_ready), 288'(1));
    for (int i = 0; i < 16; i++) msgs[i] = 13'(800 + i);
    fill_block("mrst");
    drain("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/an_encoder_n37_4x4.md
AN_ENCODER_N37_4X4 -- requirements
Module: an_encoder_n37_4x4

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock, rising-edge.
REQ-002 The block SHALL have the port `rst_n`: input, 1 bit, reset, asynchronous and active-low.
REQ-003 The block SHALL have the port `clear`: input, 1 bit, synchronous abort of a partially filled block.
REQ-004 The block SHALL have the port `in_valid`: input, 1 bit, message-present qualifier.
REQ-005 The block SHALL have the port `in_ready`: output, 1 bit, block accepts a message this cycle.
REQ-006 The block SHALL have the port `in_msg`: input, 13 bits, unsigned message.
REQ-007 The block SHALL have the port `out_valid`: output, 1 bit, a complete 4x4 codeword block is presented.
REQ-008 The block SHALL have the port `out_ready`: input, 1 bit, downstream accepts the block.
REQ-009 The block SHALL have the port `out_block`: output, 288 bits, 16 codewords; slot i occupies bits [18i+17:18i].
REQ-010 The block SHALL have the port `blk_err`: output, 1 bit, at least one message in the presented block was out of range (only when AN_RANGE_CHECK_EN is defined; otherwise tied 0).

Function
REQ-011 Encoding SHALL be the AN code with A=37: codeword = 37*m, computed as (m<<5)+(m<<2)+m.
- Width: 19-bit sum, result truncated to 18 bits.
REQ-012 Slot order SHALL be row-major: slot i = row i/4, column i%4, matching the 4x4 decoder array layout IN0..IN15.
REQ-013 The FSM SHALL have two states.
- FILL: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-014 In FILL, a handshake (in_valid&in_ready) SHALL write the encoded codeword into slot cnt and increment the 4-bit counter cnt.
REQ-015 The handshake with cnt=15 SHALL move the FSM to HOLD and wrap cnt to 0.
- out_valid rises on the next clock edge; latency is 1 cycle from the 16th accept.
REQ-016 In HOLD, out_block and blk_err SHALL be held stable until out_valid&out_ready.
- On that handshake the FSM returns to FILL on the same edge.
- in_ready rises the following cycle; there is no overlap of fill and drain.
REQ-017 In_msg and in_valid SHALL be ignored while in HOLD.
REQ-018 Clear asserted in FILL SHALL set cnt to 0 and blk_err to 0 and discard partial slots.
- Clear takes priority over a simultaneous input handshake.
REQ-019 Clear asserted in HOLD SHALL be ignored; a completed block is never dropped.
REQ-020 Slot contents not yet written in the current block SHALL retain old values; they are never presented because out_valid requires all 16 accepts.

Reset
REQ-021 On rst_n low the block SHALL reset asynchronously to state FILL.
- cnt=0, out_valid=0, blk_err=0, out_block=0.
- in_ready=1 after reset release.
REQ-022 Reset mid-fill or mid-hold SHALL discard all buffered data with no residual output.

Configuration
REQ-023 Macro AN_RANGE_CHECK_EN SHALL control range checking; the valid range is m <= 7084 (37*7084 = 262108 <= 2^18-1).
- When defined: a message > 7084 SHALL store codeword 0 in its slot and set sticky blk_err for the current block. blk_err is cleared on the output handshake, on clear, and on reset.
- When undefined: no check is made; the codeword is 37*m truncated to 18 bits, and blk_err is constant 0.

Verification
REQ-024 Scenario: after reset, 16 accepts with m = slot index 0..15 -> out_valid the cycle after the 16th accept; slot i = 37*i (slot 15 = 555); blk_err=0.
REQ-025 Scenario: m=7084 in slot 0 and m=1 in slot 15 -> slot 0 = 262108; slot 15 = 37.
REQ-026 Scenario: m=7085 in slot 3.
- With AN_RANGE_CHECK_EN: slot 3 = 0, blk_err=1.
- Without: slot 3 = 1 (262145 mod 2^18), blk_err=0.
REQ-027 Scenario: full block, then out_ready=0 for 5 cycles -> out_block stable, in_ready=0, in_valid pulses ignored. Then out_ready=1 -> in_ready=1 on the next cycle and a second block fills from slot 0.
REQ-028 Scenario: 7 accepts then clear asserted together with in_valid -> cnt=0 and that message is not stored. The next 16 accepts form a block containing only the new messages.
REQ-029 Scenario: 9 accepts then rst_n low for 1 cycle -> out_valid=0 and out_block=0 immediately; after release, 16 new accepts are required before out_valid.
